// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: the function-code decode for the ALU and
// mul/div unit, and the state encoding for the iterative mul/div engine.
package mips_pkg;

  typedef enum logic [5:0] {
    FN_SLL   = 6'b000000,
    FN_SRL   = 6'b000010,
    FN_SRA   = 6'b000011,
    FN_MFHI  = 6'b010000,
    FN_MTHI  = 6'b010001,
    FN_MFLO  = 6'b010010,
    FN_MTLO  = 6'b010011,
    FN_MULT  = 6'b011000,
    FN_MULTU = 6'b011001,
    FN_DIV   = 6'b011010,
    FN_DIVU  = 6'b011011,
    FN_ADD   = 6'b100000,
    FN_ADDU  = 6'b100001,
    FN_SUB   = 6'b100010,
    FN_SUBU  = 6'b100011,
    FN_AND   = 6'b100100,
    FN_OR    = 6'b100101,
    FN_XOR   = 6'b100110,
    FN_NOR   = 6'b100111,
    FN_SLT   = 6'b101010,
    FN_SLTU  = 6'b101011
  } fn_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_out
);

  logic [WIDTH:0] shifted_s;

  // Guarded trial subtraction; the low WIDTH bits of the difference are exact
  // whenever it is taken because the remainder stays below the divisor.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    q_out     = (shifted_s >= {1'b0, divisor});
    if (q_out) begin
      rem_out = shifted_s[WIDTH-1:0] - divisor;
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Operates on magnitudes for WIDTH cycles, then applies signs in FIXUP.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e              state_r, state_n;
  logic [CNT_W-1:0]       cnt_r;
  logic [2*WIDTH-1:0]     work_r;
  logic [WIDTH-1:0]       opnd_r, hi_r, lo_r;
  logic                   is_div_r, neg_q_r, neg_rem_r, div_zero_r, busy_r, done_r;

  logic                   start_md_s, md_div_s, md_signed_s, mthi_s, mtlo_s;
  logic [WIDTH-1:0]       a_mag_s, b_mag_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [2*WIDTH-1:0]     mul_next_s, div_next_s, prod_neg_s;
  logic [WIDTH-1:0]       div_rem_s, quo_s, rem_s, fix_hi_s, fix_lo_s;
  logic                   div_q_s;

  // Request decode and operand magnitudes.
  always_comb begin
    start_md_s  = 1'b0;
    md_div_s    = 1'b0;
    md_signed_s = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    if (start && (state_r == IDLE)) begin
      case (fn)
        FN_MULT:  begin start_md_s = 1'b1; md_signed_s = 1'b1; end
        FN_MULTU: begin start_md_s = 1'b1; end
        FN_DIV:   begin start_md_s = 1'b1; md_div_s = 1'b1; md_signed_s = 1'b1; end
        FN_DIVU:  begin start_md_s = 1'b1; md_div_s = 1'b1; end
        FN_MTHI:  mthi_s = 1'b1;
        FN_MTLO:  mtlo_s = 1'b1;
        default:  start_md_s = 1'b0;
      endcase
    end else begin
      start_md_s = 1'b0;
    end
    if (md_signed_s && a[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - a;
    end else begin
      a_mag_s = a;
    end
    if (md_signed_s && b[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - b;
    end else begin
      b_mag_s = b;
    end
  end

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (work_r[2*WIDTH-1:WIDTH]),
    .bit_in  (work_r[WIDTH-1]),
    .divisor (opnd_r),
    .rem_out (div_rem_s),
    .q_out   (div_q_s)
  );

  // Per-iteration datapath and final sign fixup.
  always_comb begin
    if (work_r[0]) begin
      mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, work_r[WIDTH-1:1]};
    div_next_s = {div_rem_s, work_r[WIDTH-2:0], div_q_s};
    prod_neg_s = {(2*WIDTH){1'b0}} - work_r;
    quo_s      = work_r[WIDTH-1:0];
    rem_s      = work_r[2*WIDTH-1:WIDTH];
    if (is_div_r) begin
      // Divide by zero leaves |a| as the remainder, so the usual sign fix restores a.
      fix_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - rem_s) : rem_s;
      if (div_zero_r) begin
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - quo_s) : quo_s;
      end
    end else if (neg_q_r) begin
      {fix_hi_s, fix_lo_s} = prod_neg_s;
    end else begin
      {fix_hi_s, fix_lo_s} = work_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    state_n = start_md_s ? CALC : IDLE;
      CALC:    state_n = (cnt_r == CNT_W'(WIDTH - 1)) ? FIXUP : CALC;
      FIXUP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // Operand capture, iteration, result write-back and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CNT_W{1'b0}};
      work_r     <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_md_s) begin
            work_r     <= {{WIDTH{1'b0}}, (md_div_s ? a_mag_s : b_mag_s)};
            opnd_r     <= md_div_s ? b_mag_s : a_mag_s;
            is_div_r   <= md_div_s;
            neg_q_r    <= md_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r  <= md_signed_s & a[WIDTH-1];
            div_zero_r <= (b == {WIDTH{1'b0}});
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
          end else if (mthi_s) begin
            hi_r <= a;
          end else if (mtlo_s) begin
            lo_r <= a;
          end
        end
        CALC: begin
          done_r <= 1'b0;
          work_r <= is_div_r ? div_next_s : mul_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        FIXUP: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
